// File: rtl/fifo_burst_arbiter.sv
// fifo_burst_arbiter: round-robin fixed-burst reader for two prefetch FIFOs feeding one tagged write stream.
// Define FIFO_BURST_ARB_STAT_EN to add burst/stall counters.
module fifo_burst_arbiter #(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned ADDR_W = 24,
  parameter logic [ADDR_W-1:0] CH0_BASE = 24'h000000,
  parameter logic [ADDR_W-1:0] CH1_BASE = 24'h100000,
  parameter logic [ADDR_W-1:0] REGION_WORDS = 24'h080000
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              arb_en,
  input  logic              ch0_vld,
  input  logic [63:0]       ch0_data,
  output logic              ch0_en,
  input  logic              ch1_vld,
  input  logic [63:0]       ch1_data,
  output logic              ch1_en,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [63:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_ch,
  output logic              out_last,
`ifdef FIFO_BURST_ARB_STAT_EN
  output logic [31:0]       stat_bursts0,
  output logic [31:0]       stat_bursts1,
  output logic [31:0]       stat_stall,
`endif
  output logic              busy
);
  localparam int CW = $clog2(BURST_LEN);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  logic [0:0] state;
  logic gnt, rr_last, gnt_vld, pop, last_beat;
  logic [ADDR_W-1:0] ptr0, ptr1, ptr, ptr_nxt;
  logic [CW-1:0] beat_cnt;
  always_comb begin
    gnt_vld = gnt ? ch1_vld : ch0_vld;
    pop = !rd_rst && state == BURST && gnt_vld && (!out_vld || out_rdy);
    ch0_en = pop && !gnt;
    ch1_en = pop && gnt;
    ptr = gnt ? ptr1 : ptr0;
    ptr_nxt = (ptr == REGION_WORDS - 1'b1) ? '0 : ptr + 1'b1;
    last_beat = beat_cnt == CW'(BURST_LEN - 1);
  end
  assign busy = state == BURST;
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state <= IDLE;
      gnt <= 1'b0;
      rr_last <= 1'b1;
      ptr0 <= '0;
      ptr1 <= '0;
      beat_cnt <= '0;
      out_vld <= 1'b0;
      out_last <= 1'b0;
      out_ch <= 1'b0;
      out_data <= '0;
      out_addr <= '0;
    end else begin
      if (state == IDLE && arb_en && (ch0_vld || ch1_vld)) begin
        gnt <= (ch0_vld && ch1_vld) ? !rr_last : ch1_vld;
        state <= BURST;
      end
      if (pop) begin
        out_vld <= 1'b1;
        out_data <= gnt ? ch1_data : ch0_data;
        out_ch <= gnt;
        out_addr <= (gnt ? CH1_BASE : CH0_BASE) + ptr;
        out_last <= last_beat;
        if (gnt) ptr1 <= ptr_nxt;
        else ptr0 <= ptr_nxt;
        // power-of-2 burst length lets the counter wrap to 0 on its own
        beat_cnt <= beat_cnt + 1'b1;
        if (last_beat) begin
          rr_last <= gnt;
          state <= IDLE;
        end
      end else if (out_rdy) out_vld <= 1'b0;
    end
  end
`ifdef FIFO_BURST_ARB_STAT_EN
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      stat_bursts0 <= '0;
      stat_bursts1 <= '0;
      stat_stall <= '0;
    end else begin
      if (out_vld && out_rdy && out_last && !out_ch) stat_bursts0 <= stat_bursts0 + 1'b1;
      if (out_vld && out_rdy && out_last && out_ch) stat_bursts1 <= stat_bursts1 + 1'b1;
      if (busy && !gnt_vld) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// tb_fifo_burst_arbiter: randomized scoreboard bench; FIFOs are modelled as queues, expected beats derived from
// per-channel word counts (address = base + count mod region, last every BL-th word).
module tb_fifo_burst_arbiter;
  localparam int BL = 16;
  localparam logic [23:0] B0 = 24'h000000;
  localparam logic [23:0] B1 = 24'h100000;
  localparam logic [23:0] RW = 24'h000040;
  typedef struct packed {
    logic [63:0] d;
    logic [23:0] a;
    logic c;
    logic l;
  } beat_t;
  logic rd_clk = 1'b0, rd_rst = 1'b1, arb_en = 1'b0, ch0_vld = 1'b0, ch1_vld = 1'b0, out_rdy = 1'b1;
  logic [63:0] ch0_data = '0, ch1_data = '0, out_data;
  logic [23:0] out_addr;
  logic ch0_en, ch1_en, out_vld, out_ch, out_last, busy;
`ifdef FIFO_BURST_ARB_STAT_EN
  logic [31:0] stat_bursts0, stat_bursts1, stat_stall;
`endif
  fifo_burst_arbiter #(.BURST_LEN(BL), .ADDR_W(24), .CH0_BASE(B0), .CH1_BASE(B1), .REGION_WORDS(RW)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .arb_en(arb_en),
    .ch0_vld(ch0_vld), .ch0_data(ch0_data), .ch0_en(ch0_en),
    .ch1_vld(ch1_vld), .ch1_data(ch1_data), .ch1_en(ch1_en),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_addr(out_addr),
    .out_ch(out_ch), .out_last(out_last),
`ifdef FIFO_BURST_ARB_STAT_EN
    .stat_bursts0(stat_bursts0), .stat_bursts1(stat_bursts1), .stat_stall(stat_stall),
`endif
    .busy(busy));
  always #5 rd_clk = ~rd_clk;
  beat_t exp_q[$];
  logic [63:0] q0[$], q1[$];
  int bursts[$];
  int checks = 0, fails = 0;
  int cnt[2];
  int bc = 0, cur = -1, cyc = 0, firstp = -1, lastp = -1;
  bit g0 = 1, g1 = 1, rnd_rdy = 0, rnd_gate = 0, p0, p1;
  function automatic void chk(string n, logic [95:0] act, logic [95:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", n, act, req);
    end
  endfunction
  function automatic void model_pop(int ch, logic [63:0] d);
    beat_t e;
    if (cur >= 0) chk("burst_lock_channel", ch, cur);
    cur = ch;
    e.d = d;
    e.a = (ch ? B1 : B0) + 24'(cnt[ch] % int'(RW));
    e.c = ch[0];
    e.l = bc == BL - 1;
    exp_q.push_back(e);
    cnt[ch]++;
    bc++;
    if (e.l) begin
      bc = 0;
      cur = -1;
      bursts.push_back(ch);
    end
  endfunction
  function automatic void model_reset();
    exp_q.delete();
    bursts.delete();
    cnt[0] = 0;
    cnt[1] = 0;
    bc = 0;
    cur = -1;
  endfunction
  task automatic drive();
    if (rnd_gate) begin
      g0 = $urandom_range(0, 3) != 0;
      g1 = $urandom_range(0, 3) != 0;
    end
    ch0_vld = g0 && q0.size() > 0;
    ch1_vld = g1 && q1.size() > 0;
    ch0_data = q0.size() > 0 ? q0[0] : '0;
    ch1_data = q1.size() > 0 ? q1[0] : '0;
    out_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask
  task automatic step();
    @(negedge rd_clk);
    p0 = ch0_en;
    p1 = ch1_en;
    if (p0 || p1) chk("one_hot_en", {p0, p1} == 2'b11, 0);
    if (p0) begin
      chk("pop0_needs_vld", ch0_vld, 1);
      model_pop(0, q0[0]);
      if (firstp < 0) firstp = cyc;
      lastp = cyc;
    end
    if (p1) begin
      chk("pop1_needs_vld", ch1_vld, 1);
      model_pop(1, q1[0]);
    end
    @(posedge rd_clk);
    #1;
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    cyc++;
    drive();
  endtask
  task automatic fill(int ch, int n);
    for (int i = 0; i < n; i++) begin
      if (ch == 0) q0.push_back({$urandom, $urandom});
      else q1.push_back({$urandom, $urandom});
    end
    drive();
  endtask
  task automatic drain(string n);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy || out_vld || exp_q.size() > 0) && k < 3000) begin
      step();
      k++;
    end
    checks++;
    if (k >= 3000) begin
      fails++;
      $display("FAIL %s_timeout actual=%0d_cycles required=<3000", n, k);
    end
    chk({n, "_exp_empty"}, exp_q.size(), 0);
  endtask
  task automatic do_reset();
    rd_rst = 1'b1;
    step();
    step();
    rd_rst = 1'b0;
    q0.delete();
    q1.delete();
    model_reset();
    g0 = 1;
    g1 = 1;
    firstp = -1;
    lastp = -1;
    drive();
  endtask
  beat_t held, e;
  bit stalled = 0;
  always @(negedge rd_clk) begin
    if (rd_rst) stalled = 0;
    else begin
      if (stalled) begin
        chk("hold_vld", out_vld, 1);
        chk("hold_beat", {out_data, out_addr, out_ch, out_last}, held);
      end
      if (out_vld && !out_rdy) chk("no_pop_while_stalled", ch0_en || ch1_en, 0);
      if (out_vld && out_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard_extra actual=addr_%0h required=no_beat", out_addr);
        end else begin
          e = exp_q.pop_front();
          if ({out_data, out_addr, out_ch, out_last} !== e) begin
            fails++;
            $display("FAIL beat actual=d%0h_a%0h_c%0d_l%0d required=d%0h_a%0h_c%0d_l%0d",
                     out_data, out_addr, out_ch, out_last, e.d, e.a, e.c, e.l);
          end
        end
      end
      stalled = out_vld && !out_rdy;
      held = {out_data, out_addr, out_ch, out_last};
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    int k;
    model_reset();
    do_reset();
    @(negedge rd_clk);
    chk("rst_out", {out_vld, out_last, out_ch, busy, ch0_en, ch1_en}, 0);
    chk("rst_data_addr", {out_data, out_addr}, 0);
    // two back-to-back ch0 bursts: 32 pops with exactly one arbitration gap
    arb_en = 1'b1;
    fill(0, 32);
    drain("t1");
    chk("t1_span", lastp - firstp, 32);
    chk("t1_bursts", bursts.size(), 2);
    // both channels busy: grants alternate starting with ch0
    do_reset();
    fill(0, 64);
    fill(1, 64);
    drain("t2");
    chk("t2_bursts", bursts.size(), 8);
    foreach (bursts[i]) chk($sformatf("t2_grant%0d", i), bursts[i], i % 2);
    // ch0 goes empty for 5 cycles after beat 7; burst must resume, not yield
    do_reset();
    fill(0, 16);
    fill(1, 16);
    k = 0;
    while (cnt[0] < 7 && k < 100) begin step(); k++; end
    chk("t3_reach_beat7", cnt[0], 7);
    g0 = 0;
    drive();
    repeat (5) begin
      step();
      chk("t3_gap_no_pop", {p0, p1}, 0);
    end
    g0 = 1;
    drive();
    drain("t3");
    chk("t3_order", {bursts.size(), bursts[0], bursts[1]}, {32'd2, 32'd0, 32'd1});
    // random back-pressure and random FIFO emptiness
    do_reset();
    rnd_rdy = 1;
    rnd_gate = 1;
    fill(0, 48);
    fill(1, 48);
    drain("t4");
    rnd_rdy = 0;
    rnd_gate = 0;
    g0 = 1;
    g1 = 1;
    chk("t4_bursts", bursts.size(), 6);
    // address wrap within a 64-word region
    do_reset();
    fill(0, 80);
    drain("t5");
    chk("t5_words", cnt[0], 80);
    // reset during beat 5 drops the partial burst
    do_reset();
    fill(0, 21);
    k = 0;
    while (cnt[0] < 5 && k < 100) begin step(); k++; end
    rd_rst = 1'b1;
    step();
    rd_rst = 1'b0;
    model_reset();
    @(negedge rd_clk);
    chk("t6_after_rst", {out_vld, busy, ch0_en}, 0);
    chk("t6_fifo_left", q0.size(), 16);
    drain("t6");
    chk("t6_bursts", bursts.size(), 1);
    // arb_en low mid-burst: current burst finishes, no new grant
    do_reset();
    fill(0, 32);
    k = 0;
    while (cnt[0] < 3 && k < 100) begin step(); k++; end
    arb_en = 1'b0;
    repeat (40) step();
    chk("t7_one_burst", cnt[0], 16);
    chk("t7_idle", {busy, out_vld}, 0);
    arb_en = 1'b1;
    drain("t7");
    chk("t7_total", cnt[0], 32);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
